ioctl_streamer: RTL
===================

# ioctl_streamer

Transmitter side of the ioctl download bus. Replays a byte stream (valid/ready source: flash reader, UART loader or bench model) as `ioctl_download` / `ioctl_wr` / `ioctl_addr` / `ioctl_dout` / `ioctl_index` transfers. Drives the core top's ROM download controller, SDRAM toggle-request path, sound-ROM DPRAM and DIP-switch capture exactly as `hps_io` does. Write pacing guarantees the SDRAM `port1_req` handshake completes before the next byte.

## Interface
- `ADDR_W`, 25: width of `ioctl_addr`.
- `GAP`, 8: minimum idle cycles after each write pulse (≥1).
- `TAIL`, 16: cycles `ioctl_download` stays high after the last write.
- `WAIT_ACK`, 0: 1 = the GAP state also waits for an `wr_ack` toggle.

Ports:
- `clk_sys` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a transfer; ignored unless IDLE.
- `index` in 8: download index, sampled on accepted `start` (0 = ROM, 1 = core_mod, 254 = DIP).
- `s_data` in 8: source byte.
- `s_valid` in 1: source byte valid.
- `s_last` in 1: qualifies the final byte.
- `s_ready` out 1: high only in FETCH.
- `wr_ack` in 1: SDRAM port ack, toggle convention.
- `ioctl_download` out 1, `ioctl_index` out 8, `ioctl_wr` out 1, `ioctl_addr` out ADDR_W, `ioctl_dout` out 8: bus outputs.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse on return to IDLE.
- `overflow` out 1: sticky until next accepted `start`; address space exhausted before `s_last`.

## Operation
- States:
  - IDLE → SETUP on `start`.
  - SETUP → FETCH after 1 cycle.
  - FETCH → WRITE on `s_valid & s_ready`.
  - WRITE → GAP after 1 cycle.
  - GAP → FETCH, or → TAIL if the byte carried `s_last` or overflow is set.
  - TAIL → IDLE after TAIL cycles.
- Accepted `start`: latch `index` into `ioctl_index`; clear the byte counter `cnt` and `overflow`; set `ioctl_download`=1.
- FETCH handshake:
  - `ioctl_dout` ← `s_data`, `ioctl_addr` ← `cnt`, `cnt` ← `cnt`+1 (ADDR_W bits, wraps).
  - Latch `s_last`.
  - If `cnt`+1 wraps to 0 and `s_last`=0, set `overflow`.
- WRITE: `ioctl_wr`=1 for exactly one cycle. Expected-ack toggles.
- GAP:
  - Count GAP cycles.
  - With WAIT_ACK=1, exit additionally requires `wr_ack` == expected-ack.
  - No timeout. Abort only by `reset_n`.
- TAIL: `ioctl_wr`=0, `ioctl_download`=1. On exit, `ioctl_download`=0 and `done`=1 on the same edge.
- `ioctl_addr`, `ioctl_dout` and `ioctl_index` remain stable from the handshake until the next handshake, and hold after IDLE.
- `start` while busy: ignored, no effect on the running transfer.

## Timing
- Reset (`reset_n`=0 at an edge): next cycle all outputs 0, state IDLE, `cnt`=0, expected-ack equals the current `wr_ack`. Applies identically mid-transfer: download drops immediately, no TAIL.
- `start` sampled at edge k → `ioctl_download`=1 from k+1; `s_ready` first high from k+2.
- Handshake at edge h → `ioctl_wr`=1 during cycle h+1 only, with addr/dout already valid.
- Minimum byte period is GAP+2 cycles when `s_valid` is held high.
- `s_ready` is combinational from state only; no dependency on `s_valid`.
- `ioctl_wr` never asserts while `ioctl_download`=0.

## Structure
- Shared package `ioctl_pkg`:
  - State enum (IDLE, SETUP, FETCH, WRITE, GAP, TAIL).
  - Index constants `IDX_ROM`=0, `IDX_MOD`=1, `IDX_DIP`=254.
- One sub-module `pace_counter`: loadable down-counter with a zero flag, used for both GAP and TAIL.
- Everything else in one always block plus the combinational `s_ready` / `busy`.

## Test plan
- `index`=0, 4 bytes 11,22,33,44 (last on 44), GAP=8:
  - exactly 4 `ioctl_wr` pulses at addr 0..3 with matching dout, 10 cycles apart;
  - download high through 16 cycles after the 4th pulse;
  - `done` once.
- `index`=254, 8 DIP bytes with `s_valid` gaps of 0–5 cycles: addr 0..7 in order, no extra pulses, `ioctl_index`=254 throughout.
- WAIT_ACK=1, `wr_ack` toggled 30 cycles after each write: next `ioctl_wr` never precedes the ack; stalled `wr_ack` holds GAP indefinitely.
- ADDR_W=4, 17 bytes without `s_last`: 16 writes at addr 0..15, then `overflow`=1, TAIL, `done`; the 17th byte is never accepted.
- `reset_n` low during GAP of byte 3: next cycle `ioctl_download`=0, `busy`=0, addr=0. A following `start` restarts at addr 0.
- `start` re-pulsed mid-transfer with `index`=1: `ioctl_index` stays 0 and the byte count is unaffected.

Source files
------------

// File: rtl/ioctl_streamer_pkg.sv
// Shared definitions for the ioctl download transmitter.
//   state_t  : transfer sequencer states
//   IDX_*    : well-known ioctl_index values seen by the core top
//   PACE_W   : width of the GAP/TAIL pacing counter
package ioctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FETCH,
    ST_WRITE,
    ST_GAP,
    ST_TAIL
  } state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  localparam int PACE_W = 16;

endpackage

// File: rtl/ioctl_streamer_pace_counter.sv
// Loadable down-counter with a zero flag. Paces both the post-write gap
// and the download tail of ioctl_streamer.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : load load_val this edge (has priority over counting)
//   load_val     : value to load
//   zero         : counter currently reads 0 (counting stops there)
module pace_counter
  import ioctl_pkg::*;
#(
  parameter int W = PACE_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)          cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ioctl_streamer.sv
// ioctl download bus transmitter. Replays a valid/ready byte stream as
// ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout / ioctl_index
// transfers, pacing writes so the SDRAM toggle handshake can finish.
//   clk_sys, reset_n         : clock, synchronous active-low reset
//   start, index             : begin a transfer with the given index (IDLE only)
//   s_data/s_valid/s_last    : source byte stream, s_ready high only in FETCH
//   wr_ack                   : SDRAM port ack (toggle), honoured when WAIT_ACK=1
//   ioctl_*                  : download bus outputs
//   busy, done, overflow     : status (done = 1-cycle pulse, overflow sticky)
module ioctl_streamer
  import ioctl_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int GAP      = 8,
  parameter int TAIL     = 16,
  parameter int WAIT_ACK = 0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        index,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              wr_ack,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  // Counter is loaded with N-1 so the state it guards lasts exactly N cycles.
  localparam logic [PACE_W-1:0] GAP_LD  = PACE_W'(GAP - 1);
  localparam logic [PACE_W-1:0] TAIL_LD = PACE_W'(TAIL - 1);

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                last_q;
  logic                exp_ack;
  logic                pace_zero;
  logic                pace_load;
  logic [PACE_W-1:0]   pace_val;
  logic                gap_exit;
  logic                to_tail;

  assign s_ready  = (state == ST_FETCH);
  assign busy     = (state != ST_IDLE);
  assign gap_exit = pace_zero && ((WAIT_ACK == 0) || (wr_ack == exp_ack));
  assign to_tail  = last_q || overflow;

  always_comb begin
    pace_load = 1'b0;
    pace_val  = GAP_LD;
    if (state == ST_WRITE) begin
      pace_load = 1'b1;
    end else if (state == ST_GAP && gap_exit && to_tail) begin
      pace_load = 1'b1;
      pace_val  = TAIL_LD;
    end
  end

  pace_counter #(.W(PACE_W)) u_pace (
    .clk      (clk_sys),
    .reset_n  (reset_n),
    .load     (pace_load),
    .load_val (pace_val),
    .zero     (pace_zero)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      last_q         <= 1'b0;
      exp_ack        <= wr_ack;   // resync so a stale ack level is not mistaken for a response
      ioctl_download <= 1'b0;
      ioctl_index    <= '0;
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      done           <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      done     <= 1'b0;
      ioctl_wr <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state          <= ST_SETUP;
          ioctl_index    <= index;
          cnt            <= '0;
          overflow       <= 1'b0;
          ioctl_download <= 1'b1;
        end
        ST_SETUP: state <= ST_FETCH;
        ST_FETCH: if (s_valid) begin
          // addr/dout land on the same edge that raises ioctl_wr
          state      <= ST_WRITE;
          ioctl_wr   <= 1'b1;
          ioctl_dout <= s_data;
          ioctl_addr <= cnt;
          cnt        <= cnt + 1'b1;
          last_q     <= s_last;
          if ((&cnt) && !s_last) overflow <= 1'b1;
        end
        ST_WRITE: begin
          state   <= ST_GAP;
          exp_ack <= ~exp_ack;
        end
        ST_GAP: if (gap_exit) state <= to_tail ? ST_TAIL : ST_FETCH;
        ST_TAIL: if (pace_zero) begin
          state          <= ST_IDLE;
          ioctl_download <= 1'b0;
          done           <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
